// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame constants and receiver state encoding
package i2s_pkg;

  localparam int FRAME_W_DEF     = 32;
  localparam int HALF_W_DEF      = FRAME_W_DEF / 2;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_UNLOCKED  = 1'b0,
    ST_RECEIVING = 1'b1
  } state_e;

endpackage

// File: rtl/i2s_sync.sv
// rtl/i2s_sync.sv - multi-flop synchronizer with per-bit rising-edge detect
module i2s_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign q_o    = stage_q[STAGES-1];
  assign rise_o = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: oversampled bit capture, frame lock, valid/ready output
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               MasterCLK,
  input  logic               RSTn,
  input  logic               I2S_CLK,
  input  logic               I2S_WS,
  input  logic               I2S_DATA,
  output logic [FRAME_W-1:0] OutData,
  output logic               OutValid,
  input  logic               OutReady,
  output logic               Overrun,
  output logic               FrameErr,
  output logic               Locked
);

  localparam int               HALF_W   = FRAME_W / 2;
  localparam int               CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  logic       sample;
  logic       ws_s, data_s;
  logic       sclk_level_unused;
  logic [1:0] wd_rise_unused;

  i2s_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i (MasterCLK),
    .rst_ni(RSTn),
    .d_i   (I2S_CLK),
    .q_o   (sclk_level_unused),
    .rise_o(sample)
  );

  i2s_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_wd (
    .clk_i (MasterCLK),
    .rst_ni(RSTn),
    .d_i   ({I2S_WS, I2S_DATA}),
    .q_o   ({ws_s, data_s}),
    .rise_o(wd_rise_unused)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-2:0]   shift_q, shift_d;
  logic                 ws_prev_q, ws_prev_d;
  logic [FRAME_W-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;

  logic ws_rise, ws_fall, receiving;
  logic lock_start, err_rise, err_fall, shift_bit, frame_done;

  // WS edges are judged only against the previously sampled bit, never the raw line
  assign receiving  = (state_q == ST_RECEIVING);
  assign ws_rise    = sample &  ws_s & ~ws_prev_q;
  assign ws_fall    = sample & ~ws_s &  ws_prev_q;
  assign lock_start = ~receiving & ws_fall;
  assign err_rise   = receiving & ws_rise & (cnt_q != CNT_HALF);
  assign err_fall   = receiving & ws_fall & (cnt_q != '0);
  assign shift_bit  = receiving & sample & ~err_rise & ~err_fall;
  assign frame_done = shift_bit & (cnt_q == CNT_LAST);

  always_ff @(posedge MasterCLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED:  if (lock_start) state_d = ST_RECEIVING;
      ST_RECEIVING: if (err_rise)   state_d = ST_UNLOCKED;
      default:      state_d = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    Locked = (state_q == ST_RECEIVING);
  end

  always_comb begin
    ws_prev_d = sample ? ws_s : ws_prev_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    // an illegal falling WS edge doubles as the first bit of a fresh frame
    if (lock_start || err_fall) begin
      cnt_d      = CNT_W'(1);
      shift_d    = '0;
      shift_d[0] = data_s;
    end else if (err_rise) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (shift_bit) begin
      cnt_d   = frame_done ? '0 : cnt_q + 1'b1;
      shift_d = {shift_q[FRAME_W-3:0], data_s};
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = err_rise | err_fall;
    if (frame_done) begin
      if (!out_valid_q || OutReady) begin
        out_data_d  = {shift_q, data_s};
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge MasterCLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      ws_prev_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ws_prev_q   <= ws_prev_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign OutData  = out_data_q;
  assign OutValid = out_valid_q;
  assign Overrun  = overrun_q;
  assign FrameErr = frame_err_q;

endmodule
